// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the UART transmit arbiter: parity/baud codes (same as RxUnit)
// and the arbiter FSM state type.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'b00,
    BAUD_19200  = 2'b01,
    BAUD_57600  = 2'b10,
    BAUD_115200 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GUARD     = 3'd4
  } arb_state_e;

  // Round-robin successor of a requester index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and TxUnit-side signals of the UART transmit arbiter.
// The arbiter uses the slave view; producers plus the TxUnit form the master view.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [2*NREQ-1:0] req_parity;
  logic [2*NREQ-1:0] req_baud;
  logic [NREQ-1:0]   req_done;
  logic [NREQ-1:0]   req_err;
  logic [NREQ-1:0]   grant;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [1:0]        tx_parity;
  logic [1:0]        tx_baud;
  logic              tx_busy;

  modport slave (
    input  req_valid, req_data, req_parity, req_baud, tx_busy,
    output req_done, req_err, grant, tx_start, tx_data, tx_parity, tx_baud
  );

  modport master (
    output req_valid, req_data, req_parity, req_baud, tx_busy,
    input  req_done, req_err, grant, tx_start, tx_data, tx_parity, tx_baud
  );
endinterface

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin pick: rotate the request vector so the pointer sits at bit 0,
// take the lowest set bit, then rotate the index back.
module uart_rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx,
  output logic [NREQ-1:0]  o_onehot
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDX_W-1:0]  w_off;
  logic [IDX_W:0]    w_sum;
  logic              w_found;

  always_comb begin
    w_dbl   = {i_valid, i_valid} >> i_ptr;
    w_rot   = w_dbl[NREQ-1:0];
    o_any   = |i_valid;
    w_off   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_rot[k] && !w_found) begin
        w_found = 1'b1;
        w_off   = IDX_W'(k);
      end
    end
    w_sum = {1'b0, w_off} + {1'b0, i_ptr};
    if (w_sum >= (IDX_W+1)'(NREQ)) w_sum = w_sum - (IDX_W+1)'(NREQ);
    o_idx    = w_sum[IDX_W-1:0];
    o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TxUnit among NREQ requesters: round-robin grant, latch the winner's
// byte/parity/baud, run the start/busy handshake and return a done or error pulse.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 1024,
  parameter int GUARD_CYCLES  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  uart_tx_arbiter_if.slave  io_bus
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (START_TIMEOUT > GUARD_CYCLES) ? START_TIMEOUT : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GD_LAST = (GUARD_CYCLES == 0) ? '0 : CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

  arb_state_e       r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_ptr, r_win;
  logic [NREQ-1:0]  r_grant;
  logic [7:0]       r_data;
  logic [1:0]       r_par, r_baud;

  logic             w_any, w_load, w_start, w_done, w_err;
  logic [IDX_W-1:0] w_idx;
  logic [NREQ-1:0]  w_onehot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + CNT_W'(1);
  endfunction

  uart_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .i_valid  (io_bus.req_valid),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_load    = 1'b0;
    w_start   = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load = 1'b1;
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_start   = 1'b1;
        w_cnt_nxt = '0;
        w_next    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Busy already high here is accepted as the frame start; no second strobe.
        if (io_bus.tx_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_cnt >= TO_LAST) begin
          w_err     = 1'b1;
          w_cnt_nxt = '0;
          w_next    = S_GUARD;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      S_WAIT_DONE: begin
        // Staying here needs busy high, so low now is the falling edge.
        if (!io_bus.tx_busy) begin
          w_done    = 1'b1;
          w_cnt_nxt = '0;
          w_next    = S_GUARD;
        end
      end
      S_GUARD: begin
        if (r_cnt >= GD_LAST) w_next = S_IDLE;
        else                  w_cnt_nxt = sat_inc(r_cnt);
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_par   <= '0;
      r_baud  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_grant <= w_onehot;
        r_win   <= w_idx;
        r_data  <= io_bus.req_data[int'(w_idx)*8 +: 8];
        r_par   <= io_bus.req_parity[int'(w_idx)*2 +: 2];
        r_baud  <= io_bus.req_baud[int'(w_idx)*2 +: 2];
      end else if (w_done || w_err) begin
        // Advancing on errors too keeps a dead requester from starving the rest.
        r_grant <= '0;
        r_ptr   <= IDX_W'(rr_next(int'(r_win), NREQ));
      end
    end
  end

  assign io_bus.grant     = r_grant;
  assign io_bus.tx_start  = w_start;
  assign io_bus.tx_data   = r_data;
  assign io_bus.tx_parity = r_par;
  assign io_bus.tx_baud   = r_baud;
  assign io_bus.req_done  = w_done ? r_grant : '0;
  assign io_bus.req_err   = w_err  ? r_grant : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter with a queue-free round-robin
// reference model and a behavioural TxUnit driven from the main sequence.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int ST   = 48;
  localparam int GC   = 3;
  localparam int GAP_EXP = ((GC == 0) ? 1 : GC) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(ST), .GUARD_CYCLES(GC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit         m_valid [NREQ];
  logic [7:0] m_data  [NREQ];
  logic [1:0] m_par   [NREQ];
  logic [1:0] m_baud  [NREQ];
  int         m_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int w);
    return (w < 0) ? '0 : (NREQ'(1) << w);
  endfunction

  // First valid requester at or after the pointer, wrapping.
  function automatic int model_pick();
    for (int j = 0; j < NREQ; j++) begin
      int k;
      k = (m_ptr + j) % NREQ;
      if (m_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic put_req(input int k, input bit v, input logic [7:0] d,
                         input logic [1:0] p, input logic [1:0] b);
    m_valid[k] = v;
    m_data[k]  = d;
    m_par[k]   = p;
    m_baud[k]  = b;
    bus.req_valid[k]          = v;
    bus.req_data[8*k +: 8]    = d;
    bus.req_parity[2*k +: 2]  = p;
    bus.req_baud[2*k +: 2]    = b;
  endtask

  task automatic set_req(input int k, input bit v);
    put_req(k, v, 8'($urandom), 2'($urandom), 2'($urandom));
  endtask

  task automatic wait_start(output int n, output bit seen, output bit leak);
    n = 0;
    leak = 1'b0;
    @(negedge clk);
    while (bus.tx_start !== 1'b1 && n < GC + ST + 20) begin
      if (bus.grant !== '0) leak = 1'b1;
      @(negedge clk);
      n++;
    end
    seen = (bus.tx_start === 1'b1);
  endtask

  // One frame: wait for the start strobe, check the latched fields, play the TxUnit.
  // Returns at the sample point of the done/error cycle.
  task automatic frame(input string tag, input bit from_gap, input int delay, input int len,
                       input bit stuck, input bit poke, output int w);
    int n;
    bit seen, leak, bad;
    logic [7:0] ed;
    wait_start(n, seen, leak);
    chk({tag, "_start_seen"}, 32'(seen), 32'd1);
    chk({tag, "_start_latency"}, 32'(n), 32'(from_gap ? GAP_EXP : 1));
    chk({tag, "_no_grant_while_idle"}, 32'(leak), 32'd0);
    w = -1;
    if (!seen) return;
    w = model_pick();
    chk({tag, "_grant"}, 32'(bus.grant), 32'(oh(w)));
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'(m_data[w]));
    chk({tag, "_tx_parity"}, 32'(bus.tx_parity), 32'(m_par[w]));
    chk({tag, "_tx_baud"}, 32'(bus.tx_baud), 32'(m_baud[w]));
    ed  = m_data[w];
    bad = 1'b0;
    if (stuck) begin
      n = 0;
      do begin
        cyc();
        @(negedge clk);
        n++;
        if (bus.tx_start !== 1'b0 || bus.req_done !== '0 || bus.tx_data !== ed) bad = 1'b1;
      end while (bus.req_err === '0 && n < ST + 8);
      chk({tag, "_err_delay"}, 32'(n), 32'(ST));
      chk({tag, "_err_vec"}, 32'(bus.req_err), 32'(oh(w)));
      chk({tag, "_quiet_while_waiting"}, 32'(bad), 32'd0);
    end else begin
      if (delay < 0) bus.tx_busy = 1'b1;
      for (int d = 0; d < delay; d++) begin
        cyc();
        @(negedge clk);
        if (bus.tx_start !== 1'b0 || bus.req_err !== '0 || bus.req_done !== '0) bad = 1'b1;
      end
      for (int i = 0; i < len; i++) begin
        cyc();
        bus.tx_busy = 1'b1;
        if (poke && i == 1) begin
          m_data[w] = ~m_data[w];
          bus.req_data[8*w +: 8] = m_data[w];
          m_valid[w] = 1'b0;
          bus.req_valid[w] = 1'b0;
        end
        @(negedge clk);
        if (bus.tx_start !== 1'b0 || bus.req_err !== '0 || bus.req_done !== '0 ||
            bus.tx_data !== ed || bus.grant !== oh(w)) bad = 1'b1;
      end
      cyc();
      bus.tx_busy = 1'b0;
      @(negedge clk);
      chk({tag, "_done_vec"}, 32'(bus.req_done), 32'(oh(w)));
      chk({tag, "_no_err"}, 32'(bus.req_err), 32'd0);
      chk({tag, "_data_held"}, 32'(bus.tx_data), 32'(ed));
      chk({tag, "_stable_in_frame"}, 32'(bad), 32'd0);
    end
    m_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    int  w, n;
    bit  seen, leak, bad;
    int  order [5];
    order = '{0, 1, 2, 3, 0};
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_parity = '0;
    bus.req_baud   = '0;
    bus.tx_busy    = 1'b0;
    for (int k = 0; k < NREQ; k++) put_req(k, 1'b0, 8'h00, 2'b00, 2'b00);

    #2 rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_tx_parity", 32'(bus.tx_parity), 32'd0);
    chk("rst_tx_baud", 32'(bus.tx_baud), 32'd0);
    chk("rst_done", 32'(bus.req_done), 32'd0);
    chk("rst_err", 32'(bus.req_err), 32'd0);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      cyc();
      @(negedge clk);
      if (bus.grant !== '0 || bus.tx_start !== 1'b0) bad = 1'b1;
    end
    chk("idle_without_requests", 32'(bad), 32'd0);

    // T1: single request, long frame
    cyc();
    put_req(0, 1'b1, 8'hA5, PAR_ODD, BAUD_57600);
    frame("T1", 1'b0, 1, 100, 1'b0, 1'b0, w);
    chk("T1_tx_data_const", 32'(bus.tx_data), 32'h0A5);
    cyc();
    set_req(0, 1'b0);
    repeat (GC + 4) cyc();

    // T5: reset during WAIT_DONE
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1);
    wait_start(n, seen, leak);
    chk("T5_start_seen", 32'(seen), 32'd1);
    chk("T5_grant", 32'(bus.grant), 32'(oh(model_pick())));
    cyc();
    bus.tx_busy = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("T5_async_grant", 32'(bus.grant), 32'd0);
    chk("T5_async_tx_data", 32'(bus.tx_data), 32'd0);
    chk("T5_async_tx_par_baud", 32'({bus.tx_parity, bus.tx_baud}), 32'd0);
    chk("T5_async_pulses", 32'({bus.tx_start, bus.req_done, bus.req_err}), 32'd0);
    bus.tx_busy = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.tx_start !== 1'b0 || bus.grant !== '0) bad = 1'b1;
    end
    chk("T5_quiet_in_reset", 32'(bad), 32'd0);
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T2: everyone valid continuously
    for (int i = 0; i < 5; i++) begin
      frame("T2", i > 0, $urandom_range(0, 3), $urandom_range(1, 12), 1'b0, 1'b0, w);
      chk("T2_order", 32'(bus.grant), 32'(oh(order[i])));
      cyc();
      if (w >= 0) set_req(w, 1'b1);
    end

    // T6: requester 3 wins, then only requester 2 -> pointer wraps
    for (int k = 0; k < 3; k++) set_req(k, 1'b0);
    frame("T6a", 1'b1, 0, 4, 1'b0, 1'b0, w);
    chk("T6a_owner", 32'(bus.grant), 32'b1000);
    cyc();
    set_req(3, 1'b0);
    set_req(2, 1'b1);
    frame("T6b", 1'b1, 2, 6, 1'b0, 1'b0, w);
    chk("T6b_owner", 32'(bus.grant), 32'b0100);

    // T3: busy never rises for requester 1; requester 2 served afterwards
    cyc();
    set_req(1, 1'b1);
    set_req(2, 1'b1);
    frame("T3a", 1'b1, 0, 0, 1'b1, 1'b0, w);
    chk("T3a_err_owner", 32'(bus.req_err), 32'b0010);
    cyc();
    set_req(1, 1'b0);
    frame("T3b", 1'b1, 0, 5, 1'b0, 1'b0, w);
    chk("T3b_owner", 32'(bus.req_done), 32'b0100);

    // T4: data and valid of the owner change mid-frame
    cyc();
    set_req(2, 1'b0);
    set_req(0, 1'b1);
    frame("T4", 1'b1, 1, 10, 1'b0, 1'b1, w);
    chk("T4_owner", 32'(bus.req_done), 32'b0001);

    // Randomized traffic, including busy-before-wait and start timeouts
    cyc();
    for (int r = 0; r < 14; r++) begin
      int mask;
      mask = $urandom_range(1, (1 << NREQ) - 1);
      for (int k = 0; k < NREQ; k++)
        if (mask[k] && !m_valid[k]) set_req(k, 1'b1);
      frame("RND", 1'b1, int'($urandom_range(0, 4)) - 1, $urandom_range(1, 15),
            $urandom_range(0, 5) == 0, 1'b0, w);
      cyc();
      if (w >= 0) set_req(w, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
